// File: rtl/trn_chnnl_cmbnr_cfg_seq_if.sv
// AXI4-Lite bundle between the configuration sequencer (master) and the
// combiner's S00_AXI register bank (slave).
interface trn_chnnl_cmbnr_cfg_seq_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                      M_AXI_AWPROT;
  logic                            M_AXI_AWVALID;
  logic                            M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID;
  logic                            M_AXI_WREADY;
  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID;
  logic                            M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                      M_AXI_ARPROT;
  logic                            M_AXI_ARVALID;
  logic                            M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID;
  logic                            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/trn_chnnl_cmbnr_cfg_seq.sv
// AXI4-Lite master that writes NUM_REGS configuration words into the combiner
// register bank on start, optionally reads them back, and reports the first error.
module trn_chnnl_cmbnr_cfg_seq #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int unsigned                   TIMEOUT_CYCLES     = 64
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   start,
  input  logic                                   verify_en,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [2:0]                             err_code,
  output logic [3:0]                             err_idx,
  trn_chnnl_cmbnr_cfg_seq_if.master              m_axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, FIN} state_t;

  localparam int unsigned DW       = C_M_AXI_DATA_WIDTH;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  IDX_LAST = 4'(NUM_REGS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  E_NONE = 3'd0, E_BRESP = 3'd1, E_RRESP = 3'd2,
                          E_RDATA = 3'd3, E_TMO = 3'd4;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   verify_q, verify_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   error_q, error_d;
  logic [2:0]             err_code_q, err_code_d;
  logic [3:0]             err_idx_q, err_idx_d;
  logic [NUM_REGS*DW-1:0] snap_q;
  logic [DW-1:0]          cur_word;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic                   aw_hs, w_hs, timed_out, tmo;

  // Address and data track idx, which only moves on state changes, so both
  // stay stable for the whole time a VALID is held.
  assign cur_word  = snap_q[DW*idx_q +: DW];
  assign cur_addr  = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx_q) << 2);
  assign aw_hs     = awvalid_q & m_axi.M_AXI_AWREADY;
  assign w_hs      = wvalid_q & m_axi.M_AXI_WREADY;
  assign timed_out = (tcnt_q == T_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    verify_d   = verify_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    tmo        = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        verify_d   = verify_en;
        error_d    = 1'b0;
        err_code_d = E_NONE;
        err_idx_d  = 4'd0;
        idx_d      = 4'd0;
        awvalid_d  = 1'b1;
        wvalid_d   = 1'b1;
        state_d    = WR;
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!(awvalid_q && !aw_hs) && !(wvalid_q && !w_hs)) state_d = WR_RESP;
        else if (timed_out) tmo = 1'b1;
      end
      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          if (m_axi.M_AXI_BRESP != 2'b00) begin
            err_code_d = E_BRESP;
            err_idx_d  = idx_q;
            state_d    = FIN;
          end else if (idx_q != IDX_LAST) begin
            idx_d     = idx_q + 4'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else if (verify_q) begin
            idx_d     = 4'd0;
            arvalid_d = 1'b1;
            state_d   = RD;
          end else begin
            state_d = FIN;
          end
        end else if (timed_out) tmo = 1'b1;
      end
      RD: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end else if (timed_out) tmo = 1'b1;
      end
      RD_DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          if (m_axi.M_AXI_RRESP != 2'b00) begin
            err_code_d = E_RRESP;
            err_idx_d  = idx_q;
            state_d    = FIN;
          end else if (m_axi.M_AXI_RDATA != cur_word) begin
            err_code_d = E_RDATA;
            err_idx_d  = idx_q;
            state_d    = FIN;
          end else if (idx_q == IDX_LAST) begin
            state_d = FIN;
          end else begin
            idx_d     = idx_q + 4'd1;
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end else if (timed_out) tmo = 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stalled slave is abandoned outright: nothing stays asserted toward it.
    if (tmo) begin
      err_code_d = E_TMO;
      err_idx_d  = idx_q;
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      arvalid_d  = 1'b0;
      state_d    = FIN;
    end
    if (state_d == FIN) error_d = (err_code_d != E_NONE);
  end

  assign tcnt_d = (state_d != state_q || state_q == IDLE) ? '0 : tcnt_q + TW'(1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      tcnt_q     <= '0;
      verify_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= E_NONE;
      err_idx_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      verify_q   <= verify_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (state_q == IDLE && start) snap_q <= cfg_data;
  end

  assign busy     = (state_q != IDLE) && (state_q != FIN);
  assign done     = (state_q == FIN);
  assign error    = error_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

  assign m_axi.M_AXI_AWADDR  = cur_addr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = cur_word;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state_q == WR_RESP);
  assign m_axi.M_AXI_ARADDR  = cur_addr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: doc/trn_chnnl_cmbnr_cfg_seq.md
Name: trn_chnnl_cmbnr_cfg_seq

Overview:
- AXI4-Lite master that programs the TRN_CHNNL_CMBNR register bank (S00_AXI) from a parallel configuration vector.
- On a start pulse it writes NUM_REGS consecutive 32-bit registers, then optionally reads each one back and compares it.
- Reports done, busy and a first-error code/index.
- Sits between system control logic and the combiner's S00_AXI slave port, replacing software-driven bring-up.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported).
- NUM_REGS, 4, registers programmed (1..16).
- BASE_ADDR, 32'h0000_0000, address of register 0; register i is at BASE_ADDR + 4*i.
- TIMEOUT_CYCLES, 64, maximum cycles per wait state before abort.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sequence
- verify_en  in  1  enable readback phase; sampled at start
- cfg_data  in  NUM_REGS*32  register values; register i = cfg_data[32*i +: 32]; sampled at start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- error  out  1  sticky; set by the last sequence if it failed
- err_code  out  3  0 none, 1 write resp error, 2 read resp error, 3 readback mismatch, 4 timeout
- err_idx  out  4  register index of first error
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR/3/1/1  write address channel; AWPROT = 0
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel; WSTRB = 4'hF
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR/3/1/1  read address channel; ARPROT = 0
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset: all VALID/READY outputs 0, busy 0, done 0, error 0, err_code 0, err_idx 0, FSM = IDLE. Reset takes effect immediately, including mid-transaction.
- IDLE:
  - start=1 snapshots cfg_data and verify_en, clears error/err_code/err_idx, sets idx=0 and busy=1, then goes to WR.
  - start while busy is ignored.
- WR:
  - AWVALID and WVALID rise together one cycle after start (or after the previous response).
  - Each VALID drops independently in the cycle after its own handshake.
  - ADDR/DATA remain stable while VALID is high.
  - Move to WR_RESP once both handshakes have completed; a same-cycle double handshake is legal.
- WR_RESP:
  - BREADY=1.
  - On BVALID with BRESP!=OKAY: err_code=1, err_idx=idx, go to FIN.
  - On BVALID with BRESP=OKAY:
    - if idx<NUM_REGS-1: idx++, go to WR;
    - else if verify: idx=0, go to RD;
    - else go to FIN.
- RD:
  - ARVALID held with ARADDR = BASE_ADDR + 4*idx until ARREADY.
  - Then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID with RRESP!=OKAY: code 2.
  - On RVALID with RDATA != snapshot[idx]: code 3.
  - Either error stops the sequence and goes to FIN.
  - Otherwise idx++; if idx wraps past NUM_REGS-1, go to FIN.
- Timeout:
  - Per-state counter reset on every state entry.
  - Reaching TIMEOUT_CYCLES in WR, WR_RESP, RD or RD_DATA sets code 4, err_idx=idx, deasserts all VALID/READY and goes to FIN.
  - This is a fatal fault; the slave must be reset before reuse.
- FIN:
  - One cycle: done=1, busy=0, error=(err_code!=0).
  - Return to IDLE.
- Only one outstanding transaction at a time. Writes and reads never overlap.
- Minimum latency per write with an always-ready slave: 3 cycles (VALID, B, next). Per read: 3 cycles.

Test Plan:
- cfg_data = {4,3,2,1}, verify_en=1, slave always ready -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads return the same values; done pulses once; error=0, err_code=0.
- AWREADY delayed 3 cycles and WREADY delayed 5 cycles on register 1 -> AWVALID/WVALID held stable with ADDR=0x4, DATA=2; each VALID drops individually after its handshake; sequence completes with no error.
- BRESP=SLVERR on register 2 -> err_code=1, err_idx=2, no AW for 0xC, no reads issued, done pulses, error=1.
- Slave returns 0xDEAD on readback of register 3 -> err_code=3, err_idx=3, error=1.
- ARREADY stuck low, TIMEOUT_CYCLES=64 -> ARVALID drops after 64 cycles, err_code=4, err_idx=0, done pulses.
- ARESETN asserted while AWVALID=1 and start pulsed while busy -> outputs go to 0 immediately, FSM returns to IDLE; a subsequent start runs a full clean sequence; the mid-sequence start had no effect.
